// File: rtl/parking_gate_ctrl_p.sv
// Single-lane parking entry controller: PIN entry, gate open/close, attempt lockout, gate timeout.
// Optional lot occupancy tracking is enabled by defining OCCUPANCY_EN.
module parking_gate_ctrl_p #(
    parameter int PIN_W        = 9,
    parameter int PIN_VALUE    = 87,
    parameter int ALARM_TRIES  = 3,
    parameter int BLOCK_TRIES  = 5,
    parameter int GATE_TIMEOUT = 1000,
    parameter int CAPACITY     = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          sensor_1,
    input  logic                          sensor_2,
    input  logic                          pin_valid,
    input  logic [PIN_W-1:0]              pin,
    input  logic                          car_exit,
    output logic                          alarm_pin,
    output logic                          alarm_block,
    output logic                          open_gate,
    output logic                          close_gate,
    output logic                          lot_full,
    output logic [$clog2(CAPACITY+1)-1:0] occupancy
);
    localparam int TRY_W = $clog2(BLOCK_TRIES + 1);
    localparam int TMR_W = (GATE_TIMEOUT > 1) ? $clog2(GATE_TIMEOUT) : 1;
    localparam int OCC_W = $clog2(CAPACITY + 1);

    localparam logic [PIN_W-1:0] PIN_REF   = PIN_W'(PIN_VALUE);
    localparam logic [TRY_W-1:0] TRY_ALARM = TRY_W'(ALARM_TRIES);
    localparam logic [TRY_W-1:0] TRY_BLOCK = TRY_W'(BLOCK_TRIES);
    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(GATE_TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_PIN, S_OPEN, S_BLOCK} state_t;

    state_t           state, state_n;
    logic [TRY_W-1:0] try_cnt, try_n, try_inc;
    logic [TMR_W-1:0] tmr, tmr_n;
    logic             pin_ok;
    logic             passed;

    assign pin_ok  = (pin == PIN_REF);
    assign try_inc = (try_cnt == TRY_BLOCK) ? try_cnt : try_cnt + 1'b1;

    always_comb begin
        state_n = state;
        try_n   = try_cnt;
        tmr_n   = '0;
        passed  = 1'b0;
        case (state)
            S_IDLE: begin
                if (sensor_1 && !lot_full) state_n = S_PIN;
            end
            S_PIN: begin
                if (pin_valid) begin
                    if (pin_ok) begin
                        state_n = S_OPEN;
                        try_n   = '0;
                    end else begin
                        try_n = try_inc;
                        if (try_inc == TRY_BLOCK) state_n = S_BLOCK;
                    end
                end else if (!sensor_1) begin
                    state_n = S_IDLE;
                end
            end
            S_OPEN: begin
                // Timer counts cycles spent in OPEN; the last one forces the close.
                if (sensor_2) begin
                    state_n = S_IDLE;
                    passed  = 1'b1;
                end else if (tmr == TMR_LAST) begin
                    state_n = S_IDLE;
                end else begin
                    tmr_n = tmr + 1'b1;
                end
            end
            S_BLOCK: begin
                if (pin_valid && pin_ok) begin
                    state_n = S_IDLE;
                    try_n   = '0;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            try_cnt     <= '0;
            tmr         <= '0;
            alarm_pin   <= 1'b0;
            alarm_block <= 1'b0;
            open_gate   <= 1'b0;
            close_gate  <= 1'b0;
        end else begin
            state       <= state_n;
            try_cnt     <= try_n;
            tmr         <= tmr_n;
            alarm_pin   <= (try_n >= TRY_ALARM);
            alarm_block <= (state_n == S_BLOCK);
            open_gate   <= (state_n == S_OPEN);
            close_gate  <= (state == S_OPEN) && (state_n == S_IDLE);
        end
    end

`ifdef OCCUPANCY_EN
    localparam logic [OCC_W-1:0] OCC_MAX = OCC_W'(CAPACITY);
    logic [OCC_W-1:0] occ_n;

    // Simultaneous entry and exit cancel out.
    always_comb begin
        occ_n = occupancy;
        if (passed && !car_exit)
            occ_n = (occupancy == OCC_MAX) ? occupancy : occupancy + 1'b1;
        else if (!passed && car_exit)
            occ_n = (occupancy == '0) ? occupancy : occupancy - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occupancy <= '0;
            lot_full  <= 1'b0;
        end else begin
            occupancy <= occ_n;
            lot_full  <= (occ_n == OCC_MAX);
        end
    end
`else
    logic occ_inputs_unused;
    assign occ_inputs_unused = car_exit | passed;
    assign occupancy = '0;
    assign lot_full  = 1'b0;
`endif

endmodule

// File: tb/tb_parking_gate_ctrl_p.sv
// Scoreboard bench for parking_gate_ctrl_p: driver queues expected output snapshots per cycle,
// monitor compares them and flags any output change that was not expected.
module tb_parking_gate_ctrl_p;
    localparam int OCC_W = 2;
`ifdef OCCUPANCY_EN
    localparam bit OCC_ON = 1'b1;
`else
    localparam bit OCC_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst, sensor_1, sensor_2, pin_valid, car_exit;
    logic [8:0]       pin;
    logic             alarm_pin, alarm_block, open_gate, close_gate, lot_full;
    logic [OCC_W-1:0] occupancy;
    logic [6:0]       outv;

    always #5 clk = ~clk;

    parking_gate_ctrl_p #(
        .PIN_W(9), .PIN_VALUE(87), .ALARM_TRIES(3), .BLOCK_TRIES(5),
        .GATE_TIMEOUT(4), .CAPACITY(2)
    ) dut (
        .clk(clk), .rst(rst), .sensor_1(sensor_1), .sensor_2(sensor_2),
        .pin_valid(pin_valid), .pin(pin), .car_exit(car_exit),
        .alarm_pin(alarm_pin), .alarm_block(alarm_block), .open_gate(open_gate),
        .close_gate(close_gate), .lot_full(lot_full), .occupancy(occupancy)
    );

    assign outv = {alarm_pin, alarm_block, open_gate, close_gate, lot_full, occupancy};

    typedef struct {
        int unsigned cyc;
        logic [6:0]  vec;
    } exp_t;

    exp_t        q[$];
    int unsigned cyc = 0;
    int          checks = 0, errors = 0;
    bit          mon_en = 1'b0;
    bit          matched;
    logic [6:0]  prev, cur;

    function automatic logic [6:0] mk(bit ap, bit ab, bit og, bit cg, int occ);
        int eff = OCC_ON ? occ : 0;
        return {ap, ab, og, cg, (eff == 2), 2'(eff)};
    endfunction

    task automatic drv(bit s1, bit s2 = 0, bit pv = 0, logic [8:0] p = 0, bit ce = 0, bit r = 0);
        @(negedge clk);
        sensor_1 = s1; sensor_2 = s2; pin_valid = pv; pin = p; car_exit = ce; rst = r;
    endtask

    // Outputs expected right after the next rising edge.
    task automatic ex(logic [6:0] v);
        exp_t e;
        e.cyc = cyc + 1;
        e.vec = v;
        q.push_back(e);
    endtask

    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (mon_en) begin
            cur     = outv;
            matched = 1'b0;
            while (q.size() > 0 && q[0].cyc < cyc) begin
                checks++; errors++;
                $display("FAIL missed_check cyc=%0d expected %b never sampled", q[0].cyc, q[0].vec);
                void'(q.pop_front());
            end
            if (q.size() > 0 && q[0].cyc == cyc) begin
                checks++;
                if (cur !== q[0].vec) begin
                    errors++;
                    $display("FAIL outputs cyc=%0d got %b expected %b", cyc, cur, q[0].vec);
                end
                void'(q.pop_front());
                matched = 1'b1;
            end
            if (!matched && cur !== prev) begin
                checks++; errors++;
                $display("FAIL unexpected_change cyc=%0d got %b previous %b", cyc, cur, prev);
            end
            prev = cur;
        end
    end

    initial begin
        rst = 1'b1; sensor_1 = 0; sensor_2 = 0; pin_valid = 0; pin = 0; car_exit = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0; prev = outv; mon_en = 1'b1;
        ex(mk(0,0,0,0,0));

        // Correct PIN, pass, close pulse; car leaves; strobe in IDLE ignored
        drv(1);
        drv(1,0,1,87);  ex(mk(0,0,1,0,0));
        drv(1);
        drv(0,1);       ex(mk(0,0,0,1,1));
        drv(0,0,0,0,1); ex(mk(0,0,0,0,0));
        drv(0,0,1,87);
        drv(0);

        // Three wrong PINs raise alarm_pin, correct PIN clears it
        drv(1);
        drv(1,0,1,5);
        drv(1);
        drv(1,0,1,5);
        drv(1,0,1,5);   ex(mk(1,0,0,0,0));
        drv(1,0,1,87);  ex(mk(0,0,1,0,0));
        drv(0,1);       ex(mk(0,0,0,1,1));
        drv(0,0,0,0,1); ex(mk(0,0,0,0,0));

        // Five wrong PINs lock out; BLOCK ignores wrong PINs and sensors
        drv(1);
        repeat (2) drv(1,0,1,5);
        drv(1,0,1,5);   ex(mk(1,0,0,0,0));
        drv(1,0,1,5);
        drv(1,0,1,5);   ex(mk(1,1,0,0,0));
        drv(1,1,1,5);
        drv(0,1);
        drv(1);
        drv(0,0,1,87);  ex(mk(0,0,0,0,0));
        drv(0);

        // Timeout close after 4 cycles in OPEN; sensor_1 in close cycle re-enters PIN
        drv(1);
        drv(1,0,1,87);  ex(mk(0,0,1,0,0));
        drv(0);
        drv(0);
        drv(0);
        drv(1);         ex(mk(0,0,0,1,0));
        drv(1);         ex(mk(0,0,0,0,0));
        drv(1,0,1,87);  ex(mk(0,0,1,0,0));
        drv(0,1);       ex(mk(0,0,0,1,1));
        drv(0,0,0,0,1); ex(mk(0,0,0,0,0));

`ifdef OCCUPANCY_EN
        // Fill the lot, confirm arrivals are held, then free a slot
        for (int k = 1; k <= 2; k++) begin
            drv(1);
            drv(1,0,1,87); ex(mk(0,0,1,0,k-1));
            drv(0,1);      ex(mk(0,0,0,1,k));
            drv(0);        ex(mk(0,0,0,0,k));
        end
        drv(1);
        drv(1);
        drv(1,0,1,87);
        drv(0,0,0,0,1); ex(mk(0,0,0,0,1));
        drv(1);
        drv(1,0,1,87);  ex(mk(0,0,1,0,1));
        drv(0,1);       ex(mk(0,0,0,1,2));
        drv(0,0,0,0,1); ex(mk(0,0,0,0,1));
        drv(0,0,0,0,1); ex(mk(0,0,0,0,0));
`endif

        // Reset while OPEN: gate drops, no close pulse
        drv(1);
        drv(1,0,1,87);    ex(mk(0,0,1,0,0));
        drv(1,0,0,0,0,1); ex(mk(0,0,0,0,0));
        drv(0);           ex(mk(0,0,0,0,0));

        // Reset clears the try counter: three fresh wrong PINs needed for alarm
        drv(1);
        drv(1,0,1,5);
        drv(1,0,1,5);
        drv(1,0,0,0,0,1);
        drv(1);
        drv(1,0,1,5);
        drv(1,0,1,5);
        drv(1,0,1,5);     ex(mk(1,0,0,0,0));
        drv(0);
        drv(0,0,0,0,0,1); ex(mk(0,0,0,0,0));
        repeat (3) drv(0);

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain got %0d pending expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/parking_gate_ctrl_p.md
Name: parking_gate_ctrl_p

Overview:
Parametrised successor of the single-lane parking entry controller. Sequences an arriving car through PIN entry, gate open and gate close. Adds explicit PIN strobes, a configurable warn/lockout attempt policy, a reachable BLOCK state, a gate-open timeout and optional lot occupancy tracking. Sits between the lane sensors/keypad front-end and the gate actuator driver.

Parameters:
PIN_W, 9, PIN width in bits
PIN_VALUE, 87, correct PIN, compared over PIN_W bits
ALARM_TRIES, 3, consecutive wrong PINs that set alarm_pin
BLOCK_TRIES, 5, consecutive wrong PINs that enter BLOCK; legal only with BLOCK_TRIES >= ALARM_TRIES >= 1
GATE_TIMEOUT, 1000, cycles in OPEN without sensor_2 before forced close; must be >= 1
CAPACITY, 64, lot capacity; used only with OCCUPANCY_EN

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
sensor_1  in  1  car present at the gate (level)
sensor_2  in  1  car has passed the gate (level)
pin_valid  in  1  one-cycle strobe; pin is a new attempt
pin  in  PIN_W  PIN attempt, sampled only when pin_valid=1
car_exit  in  1  one-cycle pulse; a car left the lot
alarm_pin  out  1  wrong-PIN warning (level)
alarm_block  out  1  lockout alarm (level)
open_gate  out  1  gate open command (level)
close_gate  out  1  gate close command (one-cycle pulse)
lot_full  out  1  occupancy == CAPACITY
occupancy  out  $clog2(CAPACITY+1)  cars in the lot

Behaviour:
- Reset: clk and rst as already decided (synchronous, active-high). All outputs are registered.
- Reset values: state IDLE, try counter 0, occupancy 0, all outputs 0. Reset mid-operation drops open_gate on the next edge and emits no close_gate pulse.
- Try counter is $clog2(BLOCK_TRIES+1) bits wide and saturates at BLOCK_TRIES. It persists across cars and clears only on a correct PIN or reset.
- IDLE: sensor_1=1 and lot_full=0 -> PIN. Otherwise stay in IDLE.
- PIN: only pin_valid cycles are evaluated. A strobe in the cycle of entry into PIN is evaluated normally.
  - Correct PIN -> OPEN. Try counter clears and alarm_pin clears; open_gate=1 from the next cycle.
  - Wrong PIN -> try counter +1.
  - alarm_pin=1 in the cycle after the counter reaches ALARM_TRIES. It holds until a correct PIN or reset.
  - If the incremented count equals BLOCK_TRIES -> BLOCK.
  - sensor_1=0 with pin_valid=0 -> IDLE; try counter is kept.
- OPEN: open_gate held at 1 and the timeout counter runs from 0.
  - sensor_2=1 -> IDLE: open_gate=0 and close_gate=1 for exactly one cycle, both registered together.
  - GATE_TIMEOUT cycles elapse with no sensor_2 -> same close sequence, but counted as no entry.
  - If sensor_1=1 during the close cycle, IDLE proceeds to PIN on the following cycle. No tailgate admission.
- BLOCK: alarm_block=1.
  - Wrong PINs are ignored.
  - A correct PIN -> IDLE and clears alarm_block, alarm_pin and the try counter.
  - sensor_1 and sensor_2 are ignored while in BLOCK.
- pin_valid outside PIN and BLOCK is ignored.
- Undefined state encodings return to IDLE.

Optional Feature:
OCCUPANCY_EN
- Defined:
  - occupancy increments on each OPEN->IDLE transition caused by sensor_2; timeouts do not count.
  - occupancy decrements on car_exit, saturating at 0.
  - Increment and decrement in the same cycle leave it unchanged; an increment at CAPACITY saturates.
  - lot_full = (occupancy == CAPACITY), registered. A full lot keeps IDLE from entering PIN.
- Undefined: car_exit ignored; occupancy and lot_full tied to 0. The ports remain present.

Test Plan:
- Reset, then sensor_1=1, then pin_valid with pin=87 -> PIN, then OPEN; open_gate=1 the cycle after the strobe. sensor_2=1 -> open_gate=0 and a single-cycle close_gate pulse.
- Three wrong PINs (pin=5) -> alarm_pin=1 after the 3rd. Correct PIN next -> alarm_pin=0, gate opens, try counter 0.
- Five wrong PINs -> BLOCK with alarm_block=1. Further wrong PIN and sensor activity -> no change. pin=87 -> IDLE, all alarms 0.
- GATE_TIMEOUT=4: open the gate and hold sensor_2=0 -> close_gate pulses 4 cycles after OPEN entry; occupancy unchanged.
- OCCUPANCY_EN with CAPACITY=2: admit two cars -> lot_full=1, and sensor_1 stays in IDLE. car_exit pulse -> occupancy=1, lot_full=0, and a new arrival proceeds.
- Assert rst while in OPEN -> next cycle all outputs 0 with no close_gate pulse. A wrong PIN then counts from 0.
